btn_move_ctrl: RTL and testbench
================================

// Module: btn_move_ctrl
// PURPOSE
//  Converts the four raw active-low push-buttons into single, debounced move commands for the game core.
//  - Synchronises and debounces each button.
//  - Detects a completed press (press then release).
//  - Arbitrates presses that complete together.
//  - Presents exactly one direction per gesture on a valid/ready handshake, then applies a cooldown.
//  - Sits between the board pins and the move/merge sequencer; replaces free-running edge latches with a clocked scheduler.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  cycles a synchronised level must be stable before it is accepted (10 ms @ 100 MHz)
//  COOLDOWN_CYCLES  2_000_000  cycles after an accepted move during which new gestures are discarded
//  DB_W             $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (localparam)
//  CD_W             $clog2(COOLDOWN_CYCLES+1)  cooldown counter width (localparam)
// PORTS
//  clk         in   1  system clock
//  rstn        in   1  asynchronous active-low reset
//  btn         in   4  raw buttons, low = pressed; [0]=up [1]=down [2]=left [3]=right
//  move_ready  in   1  game core accepts move_dir this cycle when high together with move_valid
//  move_valid  out  1  a move command is pending
//  move_dir    out  2  direction of the pending move: 0 up, 1 down, 2 left, 3 right
//  btn_level   out  4  debounced button state, high = pressed (for display/debug)
//  busy        out  1  high in the REQ and COOLDOWN states
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - All outputs are 0 and state is IDLE.
//   - Counters are cleared.
//   - Synchroniser flops and debounced levels are set to "released", so reset deassertion never produces a release event.
//  Input path, per bit:
//   - 2-FF synchroniser.
//   - Debounce counter increments while the synchronised value differs from the debounced level and clears when they match.
//   - When the counter reaches DEBOUNCE_CYCLES-1, the level toggles and the counter clears.
//   - Latency from a stable pin change to btn_level: DEBOUNCE_CYCLES+2 cycles.
//  Release event: a one-cycle pulse rel[i] on the 1->0 transition of btn_level[i]; presses alone produce nothing.
//  Arbitration: if several rel[i] pulse in the same cycle, the lowest index wins (up > down > left > right); the rest are dropped.
//  FSM:
//   - IDLE: on any rel -> REQ, latching the winning index into move_dir.
//   - REQ: move_valid=1 and move_dir is held stable. On move_ready=1 -> COOLDOWN, loading the counter with COOLDOWN_CYCLES-1 (deassertion in the next cycle).
//   - COOLDOWN: counter decrements; at 0 -> IDLE. If COOLDOWN_CYCLES=0, go straight to IDLE.
//  Dropped events:
//   - Release events arriving in REQ or COOLDOWN are discarded, not queued.
//   - A release in the same cycle as the REQ->COOLDOWN transition is also discarded.
//  Handshake:
//   - move_valid is never withdrawn before acceptance.
//   - move_dir changes only on the IDLE->REQ transition.
//   - Exactly one acceptance per REQ entry.
//  Reset mid-operation: immediately returns to IDLE with move_valid=0; a gesture in progress is lost.
//  Glitch rule: a bounce shorter than DEBOUNCE_CYCLES never changes btn_level.
// STRUCTURE
//  Shared include move_defs.vh:
//   - Direction codes DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT (2 bits).
//   - FSM state codes S_IDLE/S_REQ/S_COOLDOWN.
//   - The game core consumes the same direction codes.
//  Sub-module btn_debounce:
//   - Parameter DEBOUNCE_CYCLES; ports clk, rstn, raw_n (active-low), level.
//   - Contains the synchroniser and counter; instantiated 4x via generate.
//  The top contains release detection, the priority encoder, the FSM and the cooldown counter.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
//  1. Hold btn=4'b1110 for 10 cycles, then release.
//     -> btn_level[0] rises 6 cycles after the press; move_valid rises after btn_level[0] falls, with move_dir=0.
//     -> Holding move_ready=1 gives one accept, busy=1, then IDLE after 8 cycles.
//  2. Toggle btn[2] every 2 cycles for 20 cycles, then leave it high.
//     -> btn_level stays 0 and move_valid is never asserted.
//  3. Release btn[1] and btn[3] in the same cycle.
//     -> move_dir=1 (down); only one command; no second move_valid.
//  4. Keep move_ready=0 for 50 cycles after move_valid, and complete a btn[3] gesture meanwhile.
//     -> move_valid stays 1 and move_dir stays constant; after move_ready, no extra command (right is dropped).
//  5. Complete a gesture 3 cycles into COOLDOWN.
//     -> It is discarded. A gesture completing after return to IDLE -> a new command.
//  6. Pull rstn low while in REQ, with btn held pressed.
//     -> move_valid=0 immediately, with no command after rstn rises.
//     -> A later release of that held button is a normal gesture and yields a command.

Source files
------------

// File: rtl/btn_move_ctrl_pkg.sv
// Shared definitions for the button-to-move front end.
//   dir_e    : direction codes consumed by the game core (0 up, 1 down, 2 left, 3 right)
//   state_e  : scheduler states
//   pick_t   : priority-encoder result (hit flag + winning direction)
//   prio_pick: lowest-index-wins encoder over the four release pulses
//   cnt_width: counter width able to hold 0..n, never narrower than one bit
package btn_move_ctrl_pkg;

   localparam int NUM_BTN = 4;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_COOLDOWN = 2'd2
   } state_e;

   typedef struct packed {
      logic hit;
      dir_e dir;
   } pick_t;

   function automatic pick_t prio_pick(input logic [NUM_BTN-1:0] rel);
      pick_t p;
      p.hit = |rel;
      if (rel[0])      p.dir = DIR_UP;
      else if (rel[1]) p.dir = DIR_DOWN;
      else if (rel[2]) p.dir = DIR_LEFT;
      else if (rel[3]) p.dir = DIR_RIGHT;
      else             p.dir = DIR_UP;
      return p;
   endfunction

   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input path: 2-FF synchroniser followed by a stability counter.
//   clk, rstn : clock, asynchronous active-low reset
//   raw_n     : raw pin, low = pressed
//   level     : debounced state, high = pressed
// The synchroniser resets to "released" so reset release never looks like a
// button event. level toggles only after the synchronised value has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
   import btn_move_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw_n,
   output logic level
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST =
      (DEBOUNCE_CYCLES > 0) ? DB_W'(DEBOUNCE_CYCLES - 1) : '0;

   logic            sync1, sync2;
   logic [DB_W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw_n;
         sync2 <= sync1;
         if ((!sync2) == level) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_move_ctrl.sv
// Turns four raw active-low buttons into one move command per gesture.
//   clk, rstn  : clock, asynchronous active-low reset
//   btn[3:0]   : raw pins, low = pressed; [0] up [1] down [2] left [3] right
//   move_ready : game core accepts the pending move when high with move_valid
//   move_valid : a move command is pending (held until accepted)
//   move_dir   : direction of the pending move, changes only on IDLE->REQ
//   btn_level  : debounced button state, high = pressed
//   busy       : high while a command is pending or cooling down
// A gesture completes on release. Releases seen outside IDLE are discarded,
// including one coinciding with the acceptance edge.
module btn_move_ctrl
   import btn_move_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int COOLDOWN_CYCLES = 2_000_000
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NUM_BTN-1:0]  btn,
   input  logic                move_ready,
   output logic                move_valid,
   output logic [1:0]          move_dir,
   output logic [NUM_BTN-1:0]  btn_level,
   output logic                busy
);

   localparam int CD_W = cnt_width(COOLDOWN_CYCLES);
   localparam logic [CD_W-1:0] CD_LOAD =
      (COOLDOWN_CYCLES > 0) ? CD_W'(COOLDOWN_CYCLES - 1) : '0;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rstn  (rstn),
         .raw_n (btn[gi]),
         .level (btn_level[gi])
      );
   end

   // Release = debounced 1->0; levels reset to released so no spurious pulse.
   logic [NUM_BTN-1:0] level_q;
   logic [NUM_BTN-1:0] rel;
   pick_t              pick;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) level_q <= '0;
      else       level_q <= btn_level;
   end

   assign rel  = level_q & ~btn_level;
   assign pick = prio_pick(rel);

   state_e          state;
   logic [CD_W-1:0] cd_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         move_valid <= 1'b0;
         move_dir   <= DIR_UP;
         busy       <= 1'b0;
         cd_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick.hit) begin
                  state      <= S_REQ;
                  move_dir   <= pick.dir;
                  move_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_REQ: begin
               if (move_ready) begin
                  move_valid <= 1'b0;
                  if (COOLDOWN_CYCLES == 0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state  <= S_COOLDOWN;
                     cd_cnt <= CD_LOAD;
                  end
               end
            end
            S_COOLDOWN: begin
               if (cd_cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cd_cnt <= cd_cnt - 1'b1;
               end
            end
            default: begin
               state      <= S_IDLE;
               move_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Bench for btn_move_ctrl with short debounce/cooldown. A reference model
// derives debounced levels from a window of past pin samples and tracks the
// command scheduler as idle / pending / cooling with a remaining-cycle count.
// Every cycle the DUT outputs are compared to the model; directed scenarios
// add literal expectations, then a randomized phase runs.
module tb_btn_move_ctrl;
   localparam int D = 4;
   localparam int C = 8;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] btn;
   logic       move_ready;
   logic       move_valid;
   logic [1:0] move_dir;
   logic [3:0] btn_level;
   logic       busy;

   btn_move_ctrl #(.DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .btn        (btn),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .btn_level  (btn_level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rises = 0;
   logic pv = 1'b0;

   // ---------------- reference model ----------------
   // hist[j] holds the "pressed" pin vector sampled j+1 edges ago.
   logic [3:0] hist [0:D];
   logic [3:0] m_lvl, m_lvlq;
   int         m_st;      // 0 idle, 1 pending, 2 cooling
   logic [1:0] m_dir;
   int         m_rem;

   // A level flips once the synchronised samples (two edges old and older)
   // have all disagreed with it over the last D cycles.
   function automatic logic [3:0] f_next_lvl();
      logic [3:0] nl;
      bit all_diff;
      nl = m_lvl;
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= D; j++)
            if (hist[j][i] == m_lvl[i]) all_diff = 1'b0;
         if (all_diff) nl[i] = ~m_lvl[i];
      end
      return nl;
   endfunction

   function automatic int f_first(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (r[i]) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_lvl  <= '0;
         m_lvlq <= '0;
         m_st   <= 0;
         m_dir  <= 2'd0;
         m_rem  <= 0;
         for (int j = 0; j <= D; j++) hist[j] <= 4'b0;
      end else begin
         case (m_st)
            0: if (f_first(m_lvlq & ~m_lvl) >= 0) begin
                  m_st  <= 1;
                  m_dir <= 2'(f_first(m_lvlq & ~m_lvl));
               end
            1: if (move_ready) begin
                  m_st  <= 2;
                  m_rem <= C;
               end
            default: begin
               if (m_rem == 1) m_st <= 0;
               m_rem <= m_rem - 1;
            end
         endcase
         hist[0] <= ~btn;
         for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
         m_lvl  <= f_next_lvl();
         m_lvlq <= m_lvl;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         total++;
         if ({move_valid, move_dir, busy, btn_level} !==
             {(m_st == 1), m_dir, (m_st != 0), m_lvl}) begin
            bad++;
            $display("FAIL cycle t=%0t: dut v=%b d=%0d b=%b lvl=%b  model v=%b d=%0d b=%b lvl=%b",
                     $time, move_valid, move_dir, busy, btn_level,
                     (m_st == 1), m_dir, (m_st != 0), m_lvl);
         end
         if (move_valid && !pv) rises++;
         pv = move_valid;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (move_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      chk(name, int'(ok), 1);
   endtask

   task automatic gesture(input int idx, input int hold);
      btn[idx] = 1'b0;
      tick(hold);
      btn[idx] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, r0;
      bit flag;
      logic [1:0] d0;
      int hold;

      rstn = 1'b0; btn = 4'hF; move_ready = 1'b0;
      tick(3);
      chk("reset_valid", int'(move_valid), 0);
      chk("reset_busy",  int'(busy), 0);
      chk("reset_level", int'(btn_level), 0);
      chk("reset_dir",   int'(move_dir), 0);
      rstn = 1'b1;
      tick(2);

      // 1: up gesture, ready held high
      move_ready = 1'b1; r0 = rises;
      btn = 4'b1110;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1); n++;
         if (btn_level[0]) break;
      end
      chk("t1_press_latency", n, D + 2);
      tick(10 - n);
      btn = 4'hF;
      wait_valid("t1_valid");
      chk("t1_dir", int'(move_dir), 0);
      tick(1);
      n = 0;
      while (busy && n < 20) begin n++; tick(1); end
      chk("t1_cooldown_len", n, C);
      chk("t1_one_cmd", rises - r0, 1);
      tick(3);

      // 2: bouncing left button
      r0 = rises; flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         btn[2] = ~btn[2];
         tick(1); flag |= btn_level[2];
         tick(1); flag |= btn_level[2];
      end
      btn = 4'hF;
      for (int i = 0; i < 12; i++) begin tick(1); flag |= btn_level[2]; end
      chk("t2_no_level", int'(flag), 0);
      chk("t2_no_cmd", rises - r0, 0);

      // 3: down and right released together
      move_ready = 1'b0; r0 = rises;
      btn = 4'b0101;
      tick(8);
      btn = 4'hF;
      wait_valid("t3_valid");
      chk("t3_dir", int'(move_dir), 1);
      move_ready = 1'b1;
      tick(25);
      chk("t3_one_cmd", rises - r0, 1);

      // 4: stalled handshake, right gesture meanwhile
      move_ready = 1'b0; r0 = rises;
      gesture(0, 8);
      wait_valid("t4_valid");
      d0 = move_dir; flag = 1'b1;
      chk("t4_dir", int'(d0), 0);
      btn[3] = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (i == 8) btn[3] = 1'b1;
         tick(1);
         if (!move_valid || move_dir != d0) flag = 1'b0;
      end
      chk("t4_held", int'(flag), 1);
      move_ready = 1'b1;
      tick(30);
      chk("t4_right_dropped", rises - r0, 1);

      // 5: gesture completing 3 cycles into cooldown
      move_ready = 1'b0; r0 = rises;
      gesture(1, 8);
      wait_valid("t5_valid");
      btn[2] = 1'b0;
      tick(8);
      btn[2] = 1'b1;
      tick(3);
      move_ready = 1'b1;
      tick(25);
      chk("t5_dropped", rises - r0, 1);
      gesture(3, 8);
      wait_valid("t5_valid2");
      chk("t5_dir2", int'(move_dir), 3);
      tick(12);
      chk("t5_second_cmd", rises - r0, 2);

      // 6: reset while pending, down held across reset
      move_ready = 1'b0;
      gesture(0, 8);
      wait_valid("t6_valid");
      btn[1] = 1'b0;
      tick(8);
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst_valid", int'(move_valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      tick(3);
      rstn = 1'b1;
      r0 = rises;
      tick(20);
      chk("t6_no_cmd", rises - r0, 0);
      chk("t6_level_held", int'(btn_level[1]), 1);
      btn[1] = 1'b1;
      wait_valid("t6_valid2");
      chk("t6_dir", int'(move_dir), 1);
      move_ready = 1'b1;
      tick(12);

      // randomized phase
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            btn  = 4'($urandom);
            hold = $urandom_range(1, 12);
         end
         hold--;
         move_ready = 1'($urandom);
         tick(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
